// File: rtl/mem_port_pkg.sv
// Shared types and exception codes for the memory port responder.
package mem_port_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RSVD  = 2'd3
    } kind_e;

    localparam logic [CODE_W-1:0] INST_MISALIGN  = 4'd0;
    localparam logic [CODE_W-1:0] INST_ACCESS    = 4'd1;
    localparam logic [CODE_W-1:0] ILLEGAL        = 4'd2;
    localparam logic [CODE_W-1:0] LOAD_MISALIGN  = 4'd4;
    localparam logic [CODE_W-1:0] LOAD_ACCESS    = 4'd5;
    localparam logic [CODE_W-1:0] STORE_MISALIGN = 4'd6;
    localparam logic [CODE_W-1:0] STORE_ACCESS   = 4'd7;

    typedef struct packed {
        kind_e             kind;
        logic [XLEN-1:0]   data;
        logic              exc_valid;
        logic [CODE_W-1:0] exc_code;
        logic [XLEN-1:0]   exc_value;
    } rsp_t;

    // Misalignment outranks range; a reserved kind is always illegal.
    function automatic logic [CODE_W-1:0] exc_code_f(input kind_e kind, input logic misalign);
        logic [CODE_W-1:0] code;
        case (kind)
            FETCH:   code = misalign ? INST_MISALIGN  : INST_ACCESS;
            LOAD:    code = misalign ? LOAD_MISALIGN  : LOAD_ACCESS;
            STORE:   code = misalign ? STORE_MISALIGN : STORE_ACCESS;
            default: code = ILLEGAL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sram_bytemask.sv
// Single-port word array with byte write enables and a registered read port.
module sram_bytemask #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read data only changes on a read access, so it holds between requests.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder: one outstanding fetch/load/store with fixed latency
// and precise exception reporting.
module mem_port_responder
    import mem_port_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_kind,
    output logic [31:0] rsp_data,
    output logic        rsp_exc_valid,
    output logic [3:0]  rsp_exc_code,
    output logic [31:0] rsp_exc_value
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        rsp_valid_q;
    logic        rd_sel_q;
    rsp_t        rsp_q;
    rsp_t        rsp_c;

    logic        accept;
    kind_e       kind_d;
    logic [30:0] woff_d;
    logic        misalign_d;
    logic        oor_d;
    logic        exc_d;
    logic [3:0]  exc_code_d;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_rdata;

    assign req_ready = (state_q == S_IDLE) && !RESET;
    assign accept    = req_valid && req_ready;

    // Word offset with a borrow bit, so addresses below BASE_ADDR never wrap into range.
    assign kind_d     = kind_e'(req_kind);
    assign woff_d     = {1'b0, req_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign misalign_d = (req_addr[1:0] != 2'b00);
    assign oor_d      = woff_d[30] || (woff_d[29:0] >= 30'(DEPTH_WORDS));
    assign exc_d      = misalign_d || oor_d || (kind_d == RSVD);
    assign exc_code_d = exc_code_f(kind_d, misalign_d);

    assign mem_en = accept && !exc_d;
    assign mem_we = (kind_d == STORE);

    sram_bytemask #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk_i   (CLK),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .be_i    (req_wmask),
        .addr_i  (woff_d[AW-1:0]),
        .wdata_i (req_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rd_sel_q    <= 1'b0;
            rsp_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rsp_q.kind      <= kind_d;
                        rsp_q.data      <= 32'd0;
                        rsp_q.exc_valid <= exc_d;
                        rsp_q.exc_code  <= exc_d ? exc_code_d : 4'd0;
                        rsp_q.exc_value <= exc_d ? req_addr : 32'd0;
                        rd_sel_q        <= !exc_d && (kind_d != STORE);
                        if (exc_d || (LATENCY <= 1)) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rd_sel_q    <= 1'b0;
                        rsp_q       <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read data is taken straight from the array's output register, which holds until the next read.
    always_comb begin
        rsp_c = rsp_q;
        if (rsp_valid_q && rd_sel_q) begin
            rsp_c.data = mem_rdata;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_kind      = rsp_c.kind;
    assign rsp_data      = rsp_c.data;
    assign rsp_exc_valid = rsp_c.exc_valid;
    assign rsp_exc_code  = rsp_c.exc_code;
    assign rsp_exc_value = rsp_c.exc_value;

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed vector bench for mem_port_responder (DEPTH_WORDS=4096, BASE_ADDR=0, LATENCY=2).
module tb_mem_port_responder;

    localparam int unsigned LAT = 2;
    localparam int          NV  = 24;
    localparam int          MAX_WAIT = 20;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        exp_exc;
        logic [3:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wmask = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_kind;
    logic [31:0] rsp_data;
    logic        rsp_exc_valid;
    logic [3:0]  rsp_exc_code;
    logic [31:0] rsp_exc_value;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    mem_port_responder #(
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h0000_0000),
        .LATENCY     (LAT)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_kind      (req_kind),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_kind      (rsp_kind),
        .rsp_data      (rsp_data),
        .rsp_exc_valid (rsp_exc_valid),
        .rsp_exc_code  (rsp_exc_code),
        .rsp_exc_value (rsp_exc_value)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_kind"}, 32'(rsp_kind), 32'd0);
        check({tag, " rsp_data"}, rsp_data, 32'd0);
        check({tag, " exc_valid"}, 32'(rsp_exc_valid), 32'd0);
        check({tag, " exc_code"}, 32'(rsp_exc_code), 32'd0);
        check({tag, " exc_value"}, rsp_exc_value, 32'd0);
    endtask

    // One accept cycle; returns at the negedge of the cycle after acceptance.
    task automatic issue(input logic [1:0] kind, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        @(negedge clk);
        check("req_ready before issue", 32'(req_ready), 32'd1);
        req_kind  = kind;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Cycles from acceptance to rsp_valid; MAX_WAIT+1 if it never rises.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat <= MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid after consume"}, 32'(rsp_valid), 32'd0);
        check({tag, " req_ready after consume"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        issue(v.kind, v.addr, v.wdata, v.wmask);
        wait_rsp(lat);
        check({tag, " latency"}, 32'(lat), v.exp_exc ? 32'd1 : 32'(LAT));
        if (rsp_valid) begin
            check({tag, " kind"}, 32'(rsp_kind), 32'(v.kind));
            check({tag, " data"}, rsp_data, v.exp_data);
            check({tag, " exc_valid"}, 32'(rsp_exc_valid), 32'(v.exp_exc));
            check({tag, " exc_code"}, 32'(rsp_exc_code), v.exp_exc ? 32'(v.exp_code) : 32'd0);
            check({tag, " exc_value"}, rsp_exc_value, v.exp_exc ? v.addr : 32'd0);
            consume(tag);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] held_data;

        //          kind   addr          wdata          mask   exc   code   data
        vecs[0]  = '{2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0, 32'h0000_0000};
        vecs[1]  = '{2'd1, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b0, 4'd0, 32'hDEAD_BEEF};
        vecs[2]  = '{2'd2, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 4'd0, 32'h0000_0000};
        vecs[3]  = '{2'd2, 32'h0000_0020, 32'h0000_00AA, 4'h1, 1'b0, 4'd0, 32'h0000_0000};
        vecs[4]  = '{2'd1, 32'h0000_0020, 32'h0000_0000, 4'h0, 1'b0, 4'd0, 32'h1122_33AA};
        vecs[5]  = '{2'd1, 32'h0000_0102, 32'h0000_0000, 4'h0, 1'b1, 4'd4, 32'h0000_0000};
        vecs[6]  = '{2'd1, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b0, 4'd0, 32'hDEAD_BEEF};
        vecs[7]  = '{2'd2, 32'h0000_3FFC, 32'h5566_7788, 4'hF, 1'b0, 4'd0, 32'h0000_0000};
        vecs[8]  = '{2'd2, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd7, 32'h0000_0000};
        vecs[9]  = '{2'd1, 32'h0000_3FFC, 32'h0000_0000, 4'h0, 1'b0, 4'd0, 32'h5566_7788};
        vecs[10] = '{2'd0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 1'b1, 4'd1, 32'h0000_0000};
        vecs[11] = '{2'd0, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b0, 4'd0, 32'hDEAD_BEEF};
        vecs[12] = '{2'd2, 32'h0000_0104, 32'hCAFE_F00D, 4'hF, 1'b0, 4'd0, 32'h0000_0000};
        vecs[13] = '{2'd2, 32'h0000_0104, 32'h1234_5678, 4'h0, 1'b0, 4'd0, 32'h0000_0000};
        vecs[14] = '{2'd1, 32'h0000_0104, 32'h0000_0000, 4'h0, 1'b0, 4'd0, 32'hCAFE_F00D};
        vecs[15] = '{2'd3, 32'h0000_0200, 32'h0000_0000, 4'h0, 1'b1, 4'd2, 32'h0000_0000};
        vecs[16] = '{2'd2, 32'h0000_0102, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd6, 32'h0000_0000};
        vecs[17] = '{2'd1, 32'h0000_0100, 32'h0000_0000, 4'h0, 1'b0, 4'd0, 32'hDEAD_BEEF};
        vecs[18] = '{2'd0, 32'h0000_0102, 32'h0000_0000, 4'h0, 1'b1, 4'd0, 32'h0000_0000};
        vecs[19] = '{2'd1, 32'h0000_4000, 32'h0000_0000, 4'h0, 1'b1, 4'd5, 32'h0000_0000};
        vecs[20] = '{2'd2, 32'h0000_0040, 32'h0000_0000, 4'hF, 1'b0, 4'd0, 32'h0000_0000};
        vecs[21] = '{2'd2, 32'h0000_0040, 32'hA5A5_A5A5, 4'hA, 1'b0, 4'd0, 32'h0000_0000};
        vecs[22] = '{2'd1, 32'h0000_0040, 32'h0000_0000, 4'h0, 1'b0, 4'd0, 32'hA500_A500};
        vecs[23] = '{2'd1, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 1'b1, 4'd5, 32'h0000_0000};

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post-reset req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: fetch response held for 5 cycles must stay stable
        issue(2'd0, 32'h0000_0020, 32'h0, 4'h0);
        wait_rsp(lat);
        check("bp latency", 32'(lat), 32'(LAT));
        held_data = 32'h1122_33AA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d rsp_kind", c), 32'(rsp_kind), 32'd0);
            check($sformatf("bp%0d rsp_data", c), rsp_data, held_data);
            check($sformatf("bp%0d exc_valid", c), 32'(rsp_exc_valid), 32'd0);
            check($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
        end
        consume("bp");

        // Reset during WAIT of a load drops the response
        issue(2'd1, 32'h0000_0100, 32'h0, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst-wait req_ready", 32'(req_ready), 32'd0);
        check_outputs_zero("rst-wait");
        rst = 1'b0;
        @(negedge clk);
        check("rst-wait release req_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst-wait stale%0d", c), 32'(rsp_valid), 32'd0);
        end

        // Reset during WAIT of a store keeps the committed write
        issue(2'd2, 32'h0000_0300, 32'h0BAD_F00D, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("rst-store");
        rst = 1'b0;
        @(negedge clk);
        run_vec('{2'd1, 32'h0000_0300, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0BAD_F00D}, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
